// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//
// Execute-stage branch resolution for the pipelined RV32I core. Works out the
// real direction and target of every BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR in EX,
// compares that outcome with the fetch-stage prediction, and runs the recovery:
//   - a combinational flush of the younger stages,
//   - a held redirect to fetch (valid/ready),
//   - a one-cycle predictor update pulse.
// It also counts resolved control-flow instructions and mispredicts, and
// reports taken targets that are not word aligned.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   ex_valid/ex_stall   EX occupancy and pipeline freeze
//   ex_is_br/jal/jalr   instruction class (one-hot or all zero)
//   ex_funct3           branch compare op
//   ex_rs1/ex_rs2       forwarded operands
//   ex_pc/ex_imm        instruction PC and sign-extended immediate
//   ex_pred_taken/ex_pred_target  fetch prediction
//   redirect_ready      fetch accepts the redirect this cycle
//   flush               kill IF/ID and ID/EX at the next edge
//   redirect_valid/redirect_pc    correct next PC toward fetch
//   upd_valid/upd_pc/upd_target/upd_taken  predictor update pulse
//   misalign/misalign_pc          misaligned taken target pulse
//   br_count/mispred_count        statistics counters (wrap at 2^32)
//   dbg_state           current FSM state (0 = IDLE, 1 = HOLD)
// -----------------------------------------------------------------------------

// Branch comparator: evaluates the RV32I conditional-branch condition.
// Undefined funct3 encodings resolve as not taken.
module branch_cmp (
  input  logic [2:0]  funct3_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        taken_o
);

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (a_i == b_i);
  assign lt_s = ($signed(a_i) < $signed(b_i));
  assign lt_u = (a_i < b_i);

  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = ~eq;
      F3_BLT:  taken_o = lt_s;
      F3_BGE:  taken_o = ~lt_s;
      F3_BLTU: taken_o = lt_u;
      F3_BGEU: taken_o = ~lt_u;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

module branch_resolve_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_is_br,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        redirect_ready,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic        misalign,
  output logic [31:0] misalign_pc,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count,
  output logic        dbg_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // ---------------------------------------------------------------------------
  // Resolution datapath (pure combinational, only meaningful when fire=1)
  // ---------------------------------------------------------------------------
  logic        is_cf;
  logic        fire;
  logic        cmp_taken;
  logic        taken;
  logic [31:0] pc_rel_target;
  logic [31:0] reg_rel_target;
  logic [31:0] target;
  logic [31:0] fallthrough;
  logic [31:0] actual_next;
  logic        bad;
  logic        mispredict;
  logic        resolve_ok;
  logic        redirect_req;

  logic [0:0]  state_q, state_d;

  branch_cmp u_cmp (
    .funct3_i (ex_funct3),
    .a_i      (ex_rs1),
    .b_i      (ex_rs2),
    .taken_o  (cmp_taken)
  );

  assign is_cf = ex_is_br | ex_is_jal | ex_is_jalr;

  // Only an IDLE controller evaluates; in HOLD everything in EX is wrong-path.
  assign fire = ex_valid & ~ex_stall & is_cf & (state_q == ST_IDLE);

  assign taken = (ex_is_br & cmp_taken) | ex_is_jal | ex_is_jalr;

  assign pc_rel_target  = ex_pc + ex_imm;
  // JALR clears bit 0 of the sum; bit 1 is still checked for alignment below.
  assign reg_rel_target = (ex_rs1 + ex_imm) & ~32'h1;
  assign target         = ex_is_jalr ? reg_rel_target : pc_rel_target;
  assign fallthrough    = ex_pc + 32'd4;
  assign actual_next    = taken ? target : fallthrough;

  assign bad = taken & (target[1:0] != 2'b00);

  // The predicted target only matters when both sides agree on "taken".
  assign mispredict = ~bad & ((taken != ex_pred_taken) |
                              (taken & (ex_pred_target != target)));

  assign resolve_ok   = fire & ~bad;
  assign redirect_req = fire & mispredict;

  // ---------------------------------------------------------------------------
  // Redirect FSM
  //
  // Handshake: redirect_valid is driven high in HOLD and, together with
  // redirect_pc, stays stable until a cycle where redirect_valid and
  // redirect_ready are both high; that cycle is the transfer, and the FSM
  // returns to IDLE at the following edge. redirect_ready outside HOLD is
  // ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (redirect_req) state_d = ST_HOLD;
      ST_HOLD: if (redirect_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign dbg_state = state_q;

  // Flush is high in the resolving cycle and for the whole HOLD period,
  // including the cycle in which fetch accepts the redirect.
  assign flush          = redirect_req | (state_q == ST_HOLD);
  assign redirect_valid = (state_q == ST_HOLD);

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        upd_valid_q,   upd_valid_d;
  logic [31:0] upd_pc_q,      upd_pc_d;
  logic [31:0] upd_target_q,  upd_target_d;
  logic        upd_taken_q,   upd_taken_d;
  logic        misalign_q,    misalign_d;
  logic [31:0] misalign_pc_q, misalign_pc_d;
  logic [31:0] br_count_q,    br_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  always_comb begin
    redirect_pc_d   = redirect_pc_q;
    upd_valid_d     = resolve_ok;
    upd_pc_d        = upd_pc_q;
    upd_target_d    = upd_target_q;
    upd_taken_d     = upd_taken_q;
    misalign_d      = fire & bad;
    misalign_pc_d   = misalign_pc_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;

    // Latched once on entry to HOLD so the redirect address cannot change
    // while fetch is not ready.
    if (redirect_req) begin
      redirect_pc_d = actual_next;
    end

    if (resolve_ok) begin
      upd_pc_d     = ex_pc;
      upd_target_d = target;
      upd_taken_d  = taken;
      br_count_d   = br_count_q + 32'd1;
      if (mispredict) begin
        mispred_count_d = mispred_count_q + 32'd1;
      end
    end

    if (fire & bad) begin
      misalign_pc_d = ex_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pc_q   <= 32'd0;
      upd_valid_q     <= 1'b0;
      upd_pc_q        <= 32'd0;
      upd_target_q    <= 32'd0;
      upd_taken_q     <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_pc_q   <= 32'd0;
      br_count_q      <= 32'd0;
      mispred_count_q <= 32'd0;
    end else begin
      redirect_pc_q   <= redirect_pc_d;
      upd_valid_q     <= upd_valid_d;
      upd_pc_q        <= upd_pc_d;
      upd_target_q    <= upd_target_d;
      upd_taken_q     <= upd_taken_d;
      misalign_q      <= misalign_d;
      misalign_pc_q   <= misalign_pc_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign redirect_pc   = redirect_pc_q;
  assign upd_valid     = upd_valid_q;
  assign upd_pc        = upd_pc_q;
  assign upd_target    = upd_target_q;
  assign upd_taken     = upd_taken_q;
  assign misalign      = misalign_q;
  assign misalign_pc   = misalign_pc_q;
  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//
// Table of single-instruction resolutions with hand-computed expectations,
// followed by hand-written sequences for stall, held redirect, back-to-back
// resolution, counter wrap and asynchronous reset during HOLD.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_stall;
  logic        ex_is_br;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect_ready;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        misalign;
  logic [31:0] misalign_pc;
  logic [31:0] br_count;
  logic [31:0] mispred_count;
  logic        dbg_state;

  branch_resolve_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_is_br       (ex_is_br),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .ex_funct3      (ex_funct3),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect_ready (redirect_ready),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .misalign       (misalign),
    .misalign_pc    (misalign_pc),
    .br_count       (br_count),
    .mispred_count  (mispred_count),
    .dbg_state      (dbg_state)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_br  = 32'd0;
  logic [31:0] exp_mis = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_flush;   // mispredict: flush in N, redirect at N+1
    logic [31:0] e_rpc;
    logic        e_upd;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic        e_mis;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
    input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
    input logic [31:0] imm, input logic pt, input logic [31:0] ptgt,
    input logic e_flush, input logic [31:0] e_rpc, input logic e_upd,
    input logic e_taken, input logic [31:0] e_tgt, input logic e_mis);
    vec_t v;
    v.is_br = br; v.is_jal = jal; v.is_jalr = jalr; v.f3 = f3;
    v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm; v.pt = pt; v.ptgt = ptgt;
    v.e_flush = e_flush; v.e_rpc = e_rpc; v.e_upd = e_upd;
    v.e_taken = e_taken; v.e_tgt = e_tgt; v.e_mis = e_mis;
    return v;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic drive_cf(input logic br, input logic jal, input logic jalr,
                          input logic [2:0] f3, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] pc,
                          input logic [31:0] imm, input logic pt,
                          input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_stall = 1'b0;
    ex_is_br = br; ex_is_jal = jal; ex_is_jalr = jalr; ex_funct3 = f3;
    ex_rs1 = rs1; ex_rs2 = rs2; ex_pc = pc; ex_imm = imm;
    ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; ex_stall = 1'b0;
    ex_is_br = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0; ex_funct3 = 3'd0;
    ex_rs1 = 32'd0; ex_rs2 = 32'd0; ex_pc = 32'd0; ex_imm = 32'd0;
    ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    drive_cf(v.is_br, v.is_jal, v.is_jalr, v.f3, v.rs1, v.rs2, v.pc, v.imm, v.pt, v.ptgt);
    redirect_ready = 1'b1;
    #1;
    check({tag, "_flush_n"}, {31'd0, flush}, {31'd0, v.e_flush});
    @(negedge clk);
    drive_idle();
    if (v.e_upd) exp_br = exp_br + 32'd1;
    if (v.e_flush) exp_mis = exp_mis + 32'd1;
    #1;
    check({tag, "_rvalid"}, {31'd0, redirect_valid}, {31'd0, v.e_flush});
    check({tag, "_flush_n1"}, {31'd0, flush}, {31'd0, v.e_flush});
    if (v.e_flush) check({tag, "_rpc"}, redirect_pc, v.e_rpc);
    check({tag, "_upd_valid"}, {31'd0, upd_valid}, {31'd0, v.e_upd});
    if (v.e_upd) begin
      check({tag, "_upd_pc"}, upd_pc, v.pc);
      check({tag, "_upd_taken"}, {31'd0, upd_taken}, {31'd0, v.e_taken});
      if (v.e_taken) check({tag, "_upd_tgt"}, upd_target, v.e_tgt);
    end
    check({tag, "_misalign"}, {31'd0, misalign}, {31'd0, v.e_mis});
    if (v.e_mis) check({tag, "_mis_pc"}, misalign_pc, v.pc);
    check({tag, "_br_count"}, br_count, exp_br);
    check({tag, "_mp_count"}, mispred_count, exp_mis);
    @(negedge clk);
    #1;
    check({tag, "_rvalid_n2"}, {31'd0, redirect_valid}, 32'd0);
    check({tag, "_upd_n2"}, {31'd0, upd_valid}, 32'd0);
    check({tag, "_misalign_n2"}, {31'd0, misalign}, 32'd0);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    vecs[0]  = mk(1,0,0,3'd0,32'd5,32'd5,32'h100,32'h20,0,32'h0,         1,32'h120,1,1,32'h120,0);
    vecs[1]  = mk(1,0,0,3'd6,32'hFFFFFFFF,32'd1,32'h300,32'h40,0,32'h0,  0,32'h0,1,0,32'h0,0);
    vecs[2]  = mk(1,0,0,3'd4,32'hFFFFFFFF,32'd1,32'h200,32'hFFFFFFF8,1,32'h1F8, 0,32'h0,1,1,32'h1F8,0);
    vecs[3]  = mk(1,0,0,3'd1,32'd7,32'd7,32'h400,32'h10,1,32'h410,       1,32'h404,1,0,32'h0,0);
    vecs[4]  = mk(1,0,0,3'd5,32'hFFFFFFFB,32'd3,32'h500,32'h10,0,32'h0,  0,32'h0,1,0,32'h0,0);
    vecs[5]  = mk(1,0,0,3'd7,32'hFFFFFFFB,32'd3,32'h500,32'h10,1,32'h520, 1,32'h510,1,1,32'h510,0);
    vecs[6]  = mk(0,1,0,3'd0,32'd0,32'd0,32'h600,32'h100,0,32'h0,        1,32'h700,1,1,32'h700,0);
    vecs[7]  = mk(0,0,1,3'd0,32'h1003,32'd0,32'h800,32'h0,0,32'h0,       0,32'h0,0,0,32'h0,1);
    vecs[8]  = mk(0,0,1,3'd0,32'h1001,32'd0,32'h804,32'h0,1,32'h1000,    0,32'h0,1,1,32'h1000,0);
    vecs[9]  = mk(1,0,0,3'd2,32'd0,32'd0,32'h900,32'h20,1,32'h920,       1,32'h904,1,0,32'h0,0);
    vecs[10] = mk(0,1,0,3'd0,32'd0,32'd0,32'hA00,32'h6,0,32'h0,          0,32'h0,0,0,32'h0,1);
    vecs[11] = mk(1,0,0,3'd0,32'd1,32'd2,32'hB00,32'h2,0,32'h0,          0,32'h0,1,0,32'h0,0);
    vecs[12] = mk(0,0,1,3'd0,32'h2001,32'd0,32'hC00,32'h3,0,32'h0,       1,32'h2004,1,1,32'h2004,0);
    vecs[13] = mk(1,0,0,3'd6,32'd1,32'hFFFFFFFF,32'hE00,32'h100,1,32'hF00, 0,32'h0,1,1,32'hF00,0);
    vecs[14] = mk(1,0,0,3'd4,32'd1,32'hFFFFFFFF,32'hE00,32'h100,1,32'hF00, 1,32'hE04,1,0,32'h0,0);

    drive_idle();
    redirect_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_rvalid", {31'd0, redirect_valid}, 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    check("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
    check("rst_upd_pc", upd_pc, 32'd0);
    check("rst_upd_tgt", upd_target, 32'd0);
    check("rst_upd_taken", {31'd0, upd_taken}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_mis_pc", misalign_pc, 32'd0);
    check("rst_br_count", br_count, 32'd0);
    check("rst_mp_count", mispred_count, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply_vec(vecs[i], i);
    end

    // Stall then held redirect with a wrong-path BNE sitting in EX.
    @(negedge clk);
    drive_cf(1,0,0,3'd0,32'd5,32'd5,32'h100,32'h20,0,32'h0);
    ex_stall = 1'b1;
    redirect_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_flush", {31'd0, flush}, 32'd0);
      @(negedge clk);
      #1;
      check("stall_no_upd", {31'd0, upd_valid}, 32'd0);
    end
    ex_stall = 1'b0;
    #1;
    check("unstall_flush", {31'd0, flush}, 32'd1);
    @(negedge clk);
    drive_cf(1,0,0,3'd1,32'd1,32'd2,32'h104,32'h40,0,32'h0);
    exp_br = exp_br + 32'd1;
    exp_mis = exp_mis + 32'd1;
    #1;
    check("hold_upd_once", {31'd0, upd_valid}, 32'd1);
    check("hold_upd_pc", upd_pc, 32'h100);
    for (int i = 0; i < 4; i++) begin
      check("hold_flush", {31'd0, flush}, 32'd1);
      check("hold_rvalid", {31'd0, redirect_valid}, 32'd1);
      check("hold_rpc", redirect_pc, 32'h120);
      check("hold_br_count", br_count, exp_br);
      check("hold_mp_count", mispred_count, exp_mis);
      @(negedge clk);
      #1;
      check("hold_no_upd", {31'd0, upd_valid}, 32'd0);
    end
    redirect_ready = 1'b1;
    #1;
    check("accept_flush", {31'd0, flush}, 32'd1);
    check("accept_rvalid", {31'd0, redirect_valid}, 32'd1);
    check("accept_rpc", redirect_pc, 32'h120);
    @(negedge clk);
    drive_idle();
    redirect_ready = 1'b0;
    #1;
    check("post_accept_rvalid", {31'd0, redirect_valid}, 32'd0);
    check("post_accept_state", {31'd0, dbg_state}, 32'd0);
    check("post_accept_flush", {31'd0, flush}, 32'd0);
    check("post_accept_upd", {31'd0, upd_valid}, 32'd0);
    check("post_accept_br", br_count, exp_br);

    // Minimum redirect latency: accept at N+1, new fire at N+2.
    @(negedge clk);
    drive_cf(0,1,0,3'd0,32'd0,32'd0,32'hD00,32'h40,0,32'h0);
    #1;
    check("b2b_flush_n", {31'd0, flush}, 32'd1);
    @(negedge clk);
    drive_cf(0,1,0,3'd0,32'd0,32'd0,32'hD04,32'h80,0,32'h0);
    redirect_ready = 1'b1;
    exp_br = exp_br + 32'd1;
    exp_mis = exp_mis + 32'd1;
    #1;
    check("b2b_rvalid", {31'd0, redirect_valid}, 32'd1);
    check("b2b_rpc", redirect_pc, 32'hD40);
    @(negedge clk);
    drive_cf(1,0,0,3'd0,32'd3,32'd3,32'hD40,32'h8,1,32'hD48);
    redirect_ready = 1'b0;
    #1;
    check("b2b_idle_rvalid", {31'd0, redirect_valid}, 32'd0);
    check("b2b_idle_flush", {31'd0, flush}, 32'd0);
    @(negedge clk);
    drive_idle();
    exp_br = exp_br + 32'd1;
    #1;
    check("b2b_upd_valid", {31'd0, upd_valid}, 32'd1);
    check("b2b_upd_pc", upd_pc, 32'hD40);
    check("b2b_upd_tgt", upd_target, 32'hD48);
    check("b2b_br_count", br_count, exp_br);
    check("b2b_mp_count", mispred_count, exp_mis);

    // Counter wrap.
    @(negedge clk);
    force dut.br_count_q = 32'hFFFFFFFF;
    #1;
    release dut.br_count_q;
    #1;
    check("wrap_preset", br_count, 32'hFFFFFFFF);
    @(negedge clk);
    drive_cf(1,0,0,3'd0,32'd1,32'd2,32'hF00,32'h10,0,32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    check("wrap_br_count", br_count, 32'd0);
    check("wrap_mp_count", mispred_count, exp_mis);

    // Asynchronous reset in the middle of HOLD.
    @(negedge clk);
    drive_cf(0,1,0,3'd0,32'd0,32'd0,32'hF00,32'h40,0,32'h0);
    redirect_ready = 1'b0;
    @(posedge clk);
    #2;
    drive_idle();
    #1;
    check("arst_pre_rvalid", {31'd0, redirect_valid}, 32'd1);
    check("arst_pre_flush", {31'd0, flush}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_rvalid", {31'd0, redirect_valid}, 32'd0);
    check("arst_flush", {31'd0, flush}, 32'd0);
    check("arst_rpc", redirect_pc, 32'd0);
    check("arst_upd_valid", {31'd0, upd_valid}, 32'd0);
    check("arst_br_count", br_count, 32'd0);
    check("arst_mp_count", mispred_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("arst_after_state", {31'd0, dbg_state}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Execute-stage branch resolution controller for the pipelined RV32I core. Instantiates the branch comparator internally and computes the actual direction and target of each BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR. It checks that outcome against the fetch-stage prediction, then sequences the recovery: flush, held redirect handshake to fetch, and predictor update. It also keeps branch and mispredict statistics.

## Interface
- Parameters: none (all datapath widths 32 bits, rv32i_word).
- clk  input  1  core clock.
- rst  input  1  reset; asynchronous, active-high.
- ex_valid  input  1  EX holds a valid instruction.
- ex_stall  input  1  pipeline frozen this cycle; EX instruction not retiring from EX.
- ex_is_br / ex_is_jal / ex_is_jalr  input  1 each  instruction class (one-hot or all zero).
- ex_funct3  input  3  branch_funct3_t compare op.
- ex_rs1, ex_rs2  input  32  forwarded operands.
- ex_pc, ex_imm  input  32  instruction PC, sign-extended immediate.
- ex_pred_taken  input  1  fetch prediction for this instruction.
- ex_pred_target  input  32  predicted target (ignored when ex_pred_taken=0).
- redirect_ready  input  1  fetch accepts redirect this cycle.
- flush  output  1  kill IF/ID and ID/EX contents at next edge.
- redirect_valid  output  1  correct PC available.
- redirect_pc  output  32  correct next PC.
- upd_valid  output  1  predictor update pulse.
- upd_pc, upd_target  output  32  PC and actual target for update.
- upd_taken  output  1  actual direction.
- misalign  output  1  taken target with bits[1:0]≠0 (pulse).
- misalign_pc  output  32  PC of the offending instruction.
- br_count, mispred_count  output  32  statistics counters.

## Operation
- fire = ex_valid & ~ex_stall & (ex_is_br|ex_is_jal|ex_is_jalr) & state==IDLE. Nothing is evaluated without fire.
- taken: ex_is_br → cmp(ex_funct3, ex_rs1, ex_rs2). An undefined funct3 gives 0. JAL/JALR → 1.
- target: br/JAL → ex_pc+ex_imm. JALR → (ex_rs1+ex_imm) & ~32'h1. All sums are modulo 2^32.
- fallthrough = ex_pc+4. actual_next = taken ? target : fallthrough.
- bad = taken & target[1:0]≠0. This checks target[1] after the JALR bit-0 clear.
- mispredict = ~bad & ((taken≠ex_pred_taken) | (taken & ex_pred_target≠target)).
- FSM has two states, IDLE and HOLD.
  - IDLE→HOLD on fire & mispredict. redirect_pc is latched to actual_next.
  - HOLD→IDLE on redirect_valid & redirect_ready.
  - In HOLD, all EX instructions are wrong-path and are ignored: no update, no count, no misalign.
- flush = (fire & mispredict) | (state==HOLD). This is combinational. In HOLD it stays high through the accepting cycle.
- redirect_valid = (state==HOLD). It stays stable, with a constant redirect_pc, until accepted.
- On every fire with ~bad:
  - upd_* is registered.
  - br_count increments.
  - mispred_count increments if mispredict.
- On fire & bad: misalign and misalign_pc are registered. There is no redirect, update, or count, and the FSM stays IDLE.
- Counters wrap from 32'hFFFFFFFF to 0.

## Timing
- Reset values:
  - state IDLE
  - flush, redirect_valid, upd_valid, upd_taken, misalign all 0
  - redirect_pc, upd_pc, upd_target, misalign_pc all 0
  - both counters 0
- Resolution in cycle N (fire): flush is high in N.
  - redirect_valid rises at N+1.
  - upd_valid / misalign are high for exactly cycle N+1.
  - Counters show the new value at N+1.
- Minimum redirect latency is one cycle. If redirect_ready=1 at N+1, the FSM is IDLE at N+2 and can fire again in N+2.
- redirect_ready while IDLE has no effect.
- ex_stall=1 with a branch in EX: no fire, no outputs. Evaluation happens once, in the first unstalled cycle.
- rst asserted mid-HOLD: the pending redirect is dropped and all outputs take their reset values immediately (asynchronously).

## Test plan
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 → flush in N; redirect_valid=1, redirect_pc=0x120 at N+1; upd_taken=1; mispred_count=1; br_count=1.
- BLTU, rs1=0xFFFFFFFF, rs2=1, pred_taken=0 → not taken, correct; no flush or redirect; upd_valid pulse with upd_taken=0; mispred_count unchanged.
- BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=-8, pred_taken=1, pred_target=0x1F8 → correctly predicted; no flush; br_count increments.
- Held redirect: force a mispredict, then hold redirect_ready=0 for 4 cycles while a wrong-path BNE sits in EX → flush and redirect_valid stay high and redirect_pc stays constant; no second update; accepted on the 5th cycle; IDLE next cycle.
- JALR, rs1=0x1003, imm=0 → target 0x1002, misalign=1, misalign_pc=pc at N+1; no redirect; counters unchanged. JALR, rs1=0x1001 → target 0x1000, normal resolution.
- Async rst while in HOLD → redirect_valid and flush drop without a clock edge; both counters read 0. Also: br_count preset to 0xFFFFFFFF, then one branch → br_count wraps to 0.
